// File: rtl/idct_2d_sequencer_if.sv
// Row-in / column-out stream bundle for the 2-D IDCT sequencer.
// The slave side is the sequencer; the master side feeds rows and sinks columns.
interface idct_2d_sequencer_if #(
   parameter int WIDTH = 12
) ();
   logic               in_valid;
   logic               in_ready;
   logic [8*WIDTH-1:0] in_row;
   logic               out_valid;
   logic               out_ready;
   logic [63:0]        out_col;
   logic [2:0]         out_col_idx;
   logic               block_done;

   modport master (
      output in_valid, in_row, out_ready,
      input  in_ready, out_valid, out_col, out_col_idx, block_done
   );

   modport slave (
      input  in_valid, in_row, out_ready,
      output in_ready, out_valid, out_col, out_col_idx, block_done
   );
endinterface

// File: rtl/idct_2d_sequencer.sv
// Drives one shared 1-D IDCT through a row pass and a column pass.
// Rows land in a transpose buffer; columns are level-shifted, clamped and streamed.
module idct_2d_sequencer #(
   parameter int WIDTH       = 12,
   parameter int LEVEL_SHIFT = 128
) (
   input  logic               clk_in,
   input  logic               rst_in,
   idct_2d_sequencer_if.slave bus,
   output logic [8*WIDTH-1:0] idct_in,
   input  logic [8*WIDTH-1:0] idct_out
);

   typedef enum logic {
      ROWS,
      COLS
   } state_t;

   localparam logic signed [WIDTH:0] SHIFT_W = (WIDTH+1)'(LEVEL_SHIFT);
   localparam logic signed [WIDTH:0] PX_MAX  = (WIDTH+1)'(255);

   state_t             state_q, state_d;
   logic [2:0]         row_cnt_q, row_cnt_d;
   // bit 3 marks that all eight columns have been loaded
   logic [3:0]         col_cnt_q, col_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [63:0]        out_col_q, out_col_d;
   logic [2:0]         out_col_idx_q, out_col_idx_d;
   logic [WIDTH-1:0]   tbuf_q [8][8];
   logic [WIDTH-1:0]   tbuf_d [8][8];
   logic               in_ready_c;
   logic               out_hs;
   logic               load;

   // Level shift at WIDTH+1 bits so the full signed lane range cannot wrap.
   function automatic logic [7:0] clamp_px(input logic [WIDTH-1:0] v);
      logic signed [WIDTH:0] s;
      s = $signed({v[WIDTH-1], v}) + SHIFT_W;
      if (s[WIDTH]) return 8'd0;
      if (s > PX_MAX) return 8'hff;
      return s[7:0];
   endfunction

   assign out_hs = out_valid_q && bus.out_ready;

   // Next-state, buffer capture, column load and IDCT lane steering.
   always_comb begin
      state_d       = state_q;
      row_cnt_d     = row_cnt_q;
      col_cnt_d     = col_cnt_q;
      out_valid_d   = out_valid_q;
      out_col_d     = out_col_q;
      out_col_idx_d = out_col_idx_q;
      tbuf_d        = tbuf_q;
      idct_in       = bus.in_row;
      in_ready_c    = 1'b0;
      load          = 1'b0;
      unique case (state_q)
         ROWS: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               for (int k = 0; k < 8; k++) begin
                  tbuf_d[row_cnt_q][k] = idct_out[k*WIDTH +: WIDTH];
               end
               row_cnt_d = row_cnt_q + 3'd1;
               if (row_cnt_q == 3'd7) begin
                  state_d = COLS;
               end
            end
         end
         COLS: begin
            for (int r = 0; r < 8; r++) begin
               idct_in[r*WIDTH +: WIDTH] = tbuf_q[r][col_cnt_q[2:0]];
            end
            load = !col_cnt_q[3] && (!out_valid_q || bus.out_ready);
            if (load) begin
               for (int r = 0; r < 8; r++) begin
                  out_col_d[r*8 +: 8] = clamp_px(idct_out[r*WIDTH +: WIDTH]);
               end
               out_col_idx_d = col_cnt_q[2:0];
               out_valid_d   = 1'b1;
               col_cnt_d     = col_cnt_q + 4'd1;
            end else if (out_hs) begin
               out_valid_d = 1'b0;
            end
            if (out_hs && out_col_idx_q == 3'd7) begin
               state_d     = ROWS;
               col_cnt_d   = '0;
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q       <= ROWS;
         row_cnt_q     <= '0;
         col_cnt_q     <= '0;
         out_valid_q   <= 1'b0;
         out_col_q     <= '0;
         out_col_idx_q <= '0;
      end else begin
         state_q       <= state_d;
         row_cnt_q     <= row_cnt_d;
         col_cnt_q     <= col_cnt_d;
         out_valid_q   <= out_valid_d;
         out_col_q     <= out_col_d;
         out_col_idx_q <= out_col_idx_d;
      end
   end

   // Transpose buffer; contents after reset are never read before rewrite.
   always_ff @(posedge clk_in) begin
      tbuf_q <= tbuf_d;
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_col     = out_col_q;
   assign bus.out_col_idx = out_col_idx_q;
   assign bus.block_done  = out_hs && (out_col_idx_q == 3'd7);

endmodule
